// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
// FSM states, requester ids and store-mask width helper.
package mem_arbiter_pkg;

    localparam logic [1:0] ArbIdle = 2'd0;
    localparam logic [1:0] ArbReq  = 2'd1;
    localparam logic [1:0] ArbWait = 2'd2;

    localparam logic OwnerIfu = 1'b0;
    localparam logic OwnerLsu = 1'b1;

    function automatic int mask_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin picker for the memory-port arbiter.
// req_a is the IFU, req_b the LSU; ties go to the side not granted last.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic gnt_valid,
    output logic gnt
);

    // Pick a winner; a tie is broken against the previous grantee
    always_comb begin
        gnt_valid = req_a | req_b;
        gnt       = OwnerIfu;
        if (req_a && req_b) begin
            gnt = ~last;
        end else if (req_b) begin
            gnt = OwnerLsu;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single memory port shared by instruction fetch and load/store.
// One outstanding transaction, response routing and a sticky watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ifu_req_valid,
    output logic                          ifu_req_ready,
    input  logic [ADDR_W-1:0]             ifu_addr,
    output logic                          ifu_resp_valid,
    output logic [DATA_W-1:0]             ifu_rdata,
    input  logic                          lsu_req_valid,
    output logic                          lsu_req_ready,
    input  logic [ADDR_W-1:0]             lsu_addr,
    input  logic                          lsu_wen,
    input  logic [DATA_W-1:0]             lsu_wdata,
    input  logic [mask_width(DATA_W)-1:0] lsu_wmask,
    output logic                          lsu_resp_valid,
    output logic [DATA_W-1:0]             lsu_rdata,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_wen,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [mask_width(DATA_W)-1:0] mem_wmask,
    input  logic                          mem_resp_valid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          err_timeout
);

    localparam int MaskW = mask_width(DATA_W);
    localparam int WdogW = $clog2(TIMEOUT + 1);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             owner;
    logic             last_grant;
    logic [WdogW-1:0] wdog;

    logic             gnt_valid;
    logic             gnt;
    logic             idle;
    logic             busy;
    logic             grant_take;
    logic             resp_done;
    logic             resp_timeout;
    logic             resp_fire;
    logic [DATA_W-1:0] resp_data;

    arb_rr2 u_rr2 (
        .req_a     (ifu_req_valid),
        .req_b     (lsu_req_valid),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign idle = (state == ArbIdle);
    assign busy = (state == ArbReq) || (state == ArbWait);

    assign ifu_req_ready = rst_n && idle && gnt_valid && (gnt == OwnerIfu);
    assign lsu_req_ready = rst_n && idle && gnt_valid && (gnt == OwnerLsu);
    assign grant_take    = ifu_req_ready | lsu_req_ready;

    // A real response beats the watchdog when both land in the same cycle
    assign resp_done    = rst_n && (state == ArbWait) && mem_resp_valid;
    assign resp_timeout = rst_n && busy && (wdog == WdogLast) && !resp_done;
    assign resp_fire    = resp_done | resp_timeout;
    assign resp_data    = resp_done ? mem_rdata : '0;

    assign ifu_resp_valid = resp_fire && (owner == OwnerIfu);
    assign lsu_resp_valid = resp_fire && (owner == OwnerLsu);
    assign ifu_rdata      = ifu_resp_valid ? resp_data : '0;
    assign lsu_rdata      = lsu_resp_valid ? resp_data : '0;

    assign mem_req_valid = (state == ArbReq);

    // Next-state selection for the one-transaction handshake
    always_comb begin
        state_nxt = state;
        unique case (state)
            ArbIdle: begin
                if (grant_take) state_nxt = ArbReq;
            end
            ArbReq: begin
                if (resp_timeout)       state_nxt = ArbIdle;
                else if (mem_req_ready) state_nxt = ArbWait;
            end
            ArbWait: begin
                if (resp_fire) state_nxt = ArbIdle;
            end
            default: state_nxt = ArbIdle;
        endcase
    end

    // State, current owner and round-robin history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ArbIdle;
            owner      <= OwnerIfu;
            last_grant <= OwnerIfu;
        end else begin
            state <= state_nxt;
            if (grant_take) begin
                owner      <= gnt;
                last_grant <= gnt;
            end
        end
    end

    // Capture the winner's request; fetches always look like plain reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (grant_take) begin
            if (gnt == OwnerLsu) begin
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wdata;
                mem_wmask <= lsu_wmask;
            end else begin
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= MaskW'(0);
            end
        end
    end

    // Watchdog age of the live transaction and the sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (grant_take) begin
                wdog <= '0;
            end else if (busy) begin
                wdog <= wdog + WdogW'(1);
            end
            if (resp_timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed checks of mem_arbiter against a
// transaction-level reference model kept in this bench.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic [63:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [63:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [63:0] lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        lsu_resp_valid;
    logic [63:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W  (64),
        .DATA_W  (64),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst_n          = 1'b1;
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_wen        = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    // Reference model: one transaction in flight, tracked by whether
    // memory accepted it and how many cycles it has been alive.
    bit          m_busy = 0;
    bit          m_acc = 0;
    int          m_age = 0;
    bit          m_owner_lsu = 0;
    bit          m_last_lsu = 0;
    bit          m_err = 0;
    logic [63:0] m_addr = '0;
    bit          m_wen = 0;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_wmask = '0;

    initial begin
        forever begin
            bit          win_lsu;
            bit          win;
            bit          e_ird, e_lrd, e_mv, e_irv, e_lrv;
            bit          r_norm, r_to;
            logic [63:0] e_data;
            @(negedge clk);
            win     = 0;
            win_lsu = 0;
            e_ird = 0; e_lrd = 0; e_mv = 0; e_irv = 0; e_lrv = 0;
            r_norm = 0; r_to = 0;
            e_data = '0;
            if (!m_busy) begin
                win = ifu_req_valid || lsu_req_valid;
                if (ifu_req_valid && lsu_req_valid) win_lsu = !m_last_lsu;
                else win_lsu = lsu_req_valid;
                e_lrd = win && win_lsu;
                e_ird = win && !win_lsu;
            end else begin
                e_mv   = !m_acc;
                r_norm = m_acc && mem_resp_valid;
                r_to   = !r_norm && (m_age == TO - 1);
                e_data = r_norm ? mem_rdata : 64'h0;
                e_lrv  = (r_norm || r_to) && m_owner_lsu;
                e_irv  = (r_norm || r_to) && !m_owner_lsu;
            end
            if (rst_n) begin
                check("ifu_req_ready", ifu_req_ready, e_ird);
                check("lsu_req_ready", lsu_req_ready, e_lrd);
                check("mem_req_valid", mem_req_valid, e_mv);
                check("ifu_resp_valid", ifu_resp_valid, e_irv);
                check("lsu_resp_valid", lsu_resp_valid, e_lrv);
                check("ifu_rdata", ifu_rdata, e_irv ? e_data : 64'h0);
                check("lsu_rdata", lsu_rdata, e_lrv ? e_data : 64'h0);
                check("mem_addr", mem_addr, m_addr);
                check("mem_wen", mem_wen, m_wen);
                check("mem_wdata", mem_wdata, m_wdata);
                check("mem_wmask", mem_wmask, m_wmask);
                check("err_timeout", err_timeout, m_err);
            end
            if (!rst_n) begin
                m_busy = 0; m_acc = 0; m_age = 0; m_owner_lsu = 0;
                m_last_lsu = 0; m_err = 0; m_addr = '0; m_wen = 0;
                m_wdata = '0; m_wmask = '0;
            end else if (!m_busy) begin
                if (win) begin
                    m_busy = 1; m_acc = 0; m_age = 0;
                    m_owner_lsu = win_lsu;
                    m_last_lsu  = win_lsu;
                    if (win_lsu) begin
                        m_addr = lsu_addr; m_wen = lsu_wen;
                        m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                    end else begin
                        m_addr = ifu_addr; m_wen = 0;
                        m_wdata = '0; m_wmask = '0;
                    end
                end
            end else if (r_norm || r_to) begin
                m_busy = 0;
                if (r_to) m_err = 1;
            end else begin
                if (!m_acc && mem_req_ready) m_acc = 1;
                m_age++;
            end
        end
    end

    initial begin
        quiet();
        rst_n = 1'b0;
        tick(2);
        quiet();
        tick();
        check("reset_err", err_timeout, 1'b0);
        check("reset_addr", mem_addr, 64'h0);

        // IFU-only fetch with 1-cycle ready and 1-cycle response
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0000;
        tick();
        quiet();
        check("fetch_addr", mem_addr, 64'h8000_0000);
        mem_req_ready = 1'b1;
        tick();
        quiet();
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h0010_0073;
        tick();
        quiet();
        tick();

        // Contention right after reset: LSU, IFU, LSU
        rst_n = 1'b0;
        tick();
        quiet();
        ifu_req_valid  = 1'b1;
        ifu_addr       = 64'h8000_0100;
        lsu_req_valid  = 1'b1;
        lsu_addr       = 64'h8000_2000;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h1111_2222_3333_4444;
        tick(9);
        quiet();
        tick();

        // LSU store held in REQ for five cycles
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 64'hDEAD_BEEF_CAFE_F00D;
        lsu_wmask     = 8'hFF;
        tick();
        quiet();
        tick(5);
        check("store_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        mem_req_ready = 1'b1;
        tick();
        quiet();
        mem_resp_valid = 1'b1;
        tick();
        quiet();
        tick();

        // Memory never answers: watchdog fires, next request still served
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0200;
        tick();
        quiet();
        tick(TO + 1);
        check("timeout_err", err_timeout, 1'b1);
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_3000;
        tick();
        quiet();
        mem_req_ready = 1'b1;
        tick();
        quiet();
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h0BAD_F00D_0000_0001;
        tick();
        quiet();
        tick();

        // Reset while waiting; the late response must be dropped
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0300;
        tick();
        quiet();
        mem_req_ready = 1'b1;
        tick();
        quiet();
        rst_n = 1'b0;
        tick();
        quiet();
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h5555_AAAA_5555_AAAA;
        tick();
        quiet();
        check("midwait_err", err_timeout, 1'b0);
        tick();

        // Response on the last watchdog cycle wins over the timeout
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_4000;
        tick();
        quiet();
        mem_req_ready = 1'b1;
        tick();
        quiet();
        tick(TO - 2);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h0123_4567_89AB_CDEF;
        tick();
        quiet();
        tick();
        check("deadline_err", err_timeout, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 299) != 0);
            ifu_req_valid  = $urandom_range(0, 1) == 1;
            ifu_addr       = {$urandom, $urandom};
            lsu_req_valid  = $urandom_range(0, 1) == 1;
            lsu_addr       = {$urandom, $urandom};
            lsu_wen        = $urandom_range(0, 1) == 1;
            lsu_wdata      = {$urandom, $urandom};
            lsu_wmask      = 8'($urandom);
            mem_req_ready  = $urandom_range(0, 1) == 1;
            mem_resp_valid = $urandom_range(0, 2) == 0;
            mem_rdata      = {$urandom, $urandom};
            tick();
        end
        quiet();
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts at most one transaction at a time and forwards it to memory with a valid/ready handshake.
- Routes the memory response back to the requester that issued the transaction.
- Alternates grants under contention, and has a response watchdog that raises a sticky error.
- Sits between ifu/lsu and the memory model/bus bridge; stores use the decoder's 8-bit wmask convention.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width (wmask is DATA_W/8 bits)
TIMEOUT, 255, max cycles from entering REQ to response before watchdog fires (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  fetch data valid (1-cycle pulse)
ifu_rdata  out  DATA_W  fetch data
lsu_req_valid  in  1  load/store request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  load/store address
lsu_wen  in  1  1=store, 0=load
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  store byte mask
lsu_resp_valid  out  1  load data / store ack (1-cycle pulse)
lsu_rdata  out  DATA_W  load data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  DATA_W  registered write data
mem_wmask  out  DATA_W/8  registered mask
mem_resp_valid  in  1  memory response
mem_rdata  in  DATA_W  memory read data
err_timeout  out  1  sticky watchdog flag

Behaviour:
- FSM states: IDLE, REQ, WAIT.
- Registers:
  - owner: IFU or LSU.
  - last_grant: resets to IFU, so LSU wins the first contention.
  - latched addr/wen/wdata/wmask.
  - watchdog counter wdog.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, wdog=0, err_timeout=0, all latched fields 0.
  - Any in-flight transaction is dropped silently; no resp pulse.
- IDLE grant rule:
  - Only LSU valid -> LSU. Only IFU valid -> IFU.
  - Both valid -> the one != last_grant.
  - Winner's req_ready=1 combinationally in the same cycle; loser's ready=0.
  - At the edge: latch winner fields and owner, last_grant<=winner, state<=REQ.
  - An IFU grant latches wen=0, wdata=0, wmask=0.
- req_ready is 0 in every state other than IDLE.
- REQ:
  - mem_req_valid=1 with latched fields held stable.
  - On mem_req_ready=1 -> WAIT.
  - mem_resp_valid in REQ is ignored.
- WAIT:
  - On mem_resp_valid=1: owner's resp_valid=1 for exactly that cycle; owner's rdata=mem_rdata (combinational pass-through); state<=IDLE.
  - Stores also wait for a response, which acts as the write ack.
- No new grant in the response cycle. Back-to-back throughput is 1 transaction per 3+ cycles; minimum latency from accept to resp is 2 cycles, with mem ready and resp each in 1 cycle.
- Non-owner resp_valid is always 0. rdata outputs are 0 when their resp_valid=0.
- Watchdog:
  - wdog clears on entering REQ and increments every cycle in REQ/WAIT.
  - If wdog==TIMEOUT-1 and no response that cycle: err_timeout<=1, owner gets resp_valid=1 with rdata=0 in that cycle, state<=IDLE.
  - A response arriving in that same cycle takes precedence: normal completion, no error.
  - err_timeout clears only on reset.
- mem_req_valid=0 in IDLE/WAIT. mem_* data outputs stay at their last latched values.

Decomposition:
- Shared defines header (existing include file) gets:
  - FSM state encodings ArbIdle/ArbReq/ArbWait.
  - owner encodings OwnerIfu/OwnerLsu.
  - MaskWidth macro.
- One natural sub-module: arb_rr2, a purely combinational 2-way picker (req_a, req_b, last -> grant). All sequential logic stays in mem_arbiter.

Test Plan:
- Reset then IFU-only fetch: ifu_addr=0x80000000, mem_req_ready after 1 cycle, mem_resp_valid 1 cycle later with rdata=0x00100073 -> ifu_req_ready pulses in accept cycle; mem_addr=0x80000000, mem_wen=0; ifu_resp_valid one cycle, ifu_rdata=0x00100073; lsu_resp_valid stays 0.
- Contention after reset: both valid on the same cycle -> LSU granted first, then IFU, then LSU; three alternating grants while both are held.
- LSU store: addr=0x80001000, wdata=0xDEADBEEFCAFEF00D, wmask=0xFF, mem_req_ready held low 5 cycles -> mem_* fields stable throughout REQ; lsu_resp_valid on ack.
- Timeout: TIMEOUT=8, memory never responds -> after 8 cycles in REQ/WAIT, err_timeout=1 and owner resp_valid pulses with rdata=0; the next request is still serviced and err stays 1.
- Reset mid-WAIT: rst_n low one cycle while in WAIT, then mem_resp_valid arrives -> no resp pulse to either requester; state IDLE; err_timeout=0.
- Response at the deadline: response arrives exactly on cycle wdog==TIMEOUT-1 -> normal data delivered, err_timeout stays 0.
